// File: rtl/input_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : input_line_buffer
// Purpose  : Three-row line buffer and zero-padded ("same") 3x3 window
//            generator feeding the Conv2d MAC array. Rows arrive over an
//            AXI-Stream slave and one output row is produced per command.
// Ports    : clk, Reset (async, active-low)
//            Stream_first_row / Stream_mid_row / Stream_last_row : commands
//            IMAGE_SIZE (N), last_channel
//            dina, s_axis_tvalid, s_axis_tlast, s_axis_tready : pixel stream
//            m_axis_tready : downstream ready
//            out_window_RC (R,C = 0..2), Output_valid, Done_1row
// Revision : 1.0  initial release
// ============================================================================
module input_line_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_IMAGE_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Stream_first_row,
  input  logic                  Stream_mid_row,
  input  logic                  Stream_last_row,
  input  logic [8:0]            IMAGE_SIZE,
  input  logic                  last_channel,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] out_window_00,
  output logic [DATA_WIDTH-1:0] out_window_01,
  output logic [DATA_WIDTH-1:0] out_window_02,
  output logic [DATA_WIDTH-1:0] out_window_10,
  output logic [DATA_WIDTH-1:0] out_window_11,
  output logic [DATA_WIDTH-1:0] out_window_12,
  output logic [DATA_WIDTH-1:0] out_window_20,
  output logic [DATA_WIDTH-1:0] out_window_21,
  output logic [DATA_WIDTH-1:0] out_window_22,
  output logic                  Output_valid,
  output logic                  Done_1row
);

  localparam int c_AW = (MAX_IMAGE_SIZE > 1) ? $clog2(MAX_IMAGE_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf [3][MAX_IMAGE_SIZE];
  logic [1:0]            r_top;        // physical buffer holding the TOP row
  logic [1:0]            r_wsel;       // physical buffer being loaded
  logic                  r_two;        // first_row: a second row still follows
  logic [8:0]            r_col;
  logic                  r_tready;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_lc;
  logic                  r_cmd_last;
  logic                  r_pend_first, r_pend_mid, r_pend_last, r_pend_lc;
  logic [DATA_WIDTH-1:0] r_win [3][3];

  // tlast carries no framing information here; beat count comes from N.
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;

  function automatic logic [1:0] f_inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Physical buffer index of logical rows TOP/MID/BOT.
  logic [1:0] w_sel [3];
  assign w_sel[0] = r_top;
  assign w_sel[1] = f_inc3(r_top);
  assign w_sel[2] = f_inc3(f_inc3(r_top));

  // Commands presented during DONE are held and acted on in IDLE.
  logic w_pend_any, w_req_first, w_req_mid, w_req_last, w_cmd_lc;
  logic w_idle, w_go_first, w_go_mid, w_go_last;
  assign w_pend_any  = r_pend_first | r_pend_mid | r_pend_last;
  assign w_req_first = Stream_first_row | r_pend_first;
  assign w_req_mid   = Stream_mid_row   | r_pend_mid;
  assign w_req_last  = Stream_last_row  | r_pend_last;
  assign w_cmd_lc    = w_pend_any ? r_pend_lc : last_channel;
  assign w_idle      = (r_state == S_IDLE);
  assign w_go_first  = w_idle & w_req_first;
  assign w_go_mid    = w_idle & ~w_req_first & w_req_mid;
  assign w_go_last   = w_idle & ~w_req_first & ~w_req_mid & w_req_last;

  logic w_beat, w_last_beat, w_clr_one, w_clr_all;
  assign w_beat      = (r_state == S_LOAD) & s_axis_tvalid & r_tready;
  assign w_last_beat = (r_col == IMAGE_SIZE - 9'd1);
  // first_row zeroes the TOP row; last_row rotates the old TOP into BOT and
  // zeroes it. Both target the buffer currently pointed to by r_top.
  assign w_clr_one   = w_go_first | w_go_last;
  assign w_clr_all   = (r_state == S_DONE) & r_lc & r_cmd_last;

  // Column about to be presented: first window on EMIT entry, else next one.
  logic [8:0] w_emit_col;
  assign w_emit_col = r_valid ? (r_col + 9'd1) : r_col;

  // Pixel read with zero padding; cp is the column offset by +1 so that
  // cp==0 is column -1 and cp==N+1 is column N.
  function automatic logic [DATA_WIDTH-1:0] f_px(input logic [1:0] sel,
                                                  input logic [9:0] cp);
    logic [9:0] col;
    col = cp - 10'd1;
    if (cp == 10'd0 || cp > {1'b0, IMAGE_SIZE}) return '0;
    return r_buf[sel][col[c_AW-1:0]];
  endfunction

  // Row storage
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int b = 0; b < 3; b++)
        for (int i = 0; i < MAX_IMAGE_SIZE; i++) r_buf[b][i] <= '0;
    end else if (w_clr_all) begin
      for (int b = 0; b < 3; b++)
        for (int i = 0; i < MAX_IMAGE_SIZE; i++) r_buf[b][i] <= '0;
    end else begin
      if (w_clr_one)
        for (int i = 0; i < MAX_IMAGE_SIZE; i++) r_buf[r_top][i] <= '0;
      if (w_beat) r_buf[r_wsel][r_col[c_AW-1:0]] <= dina;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_top        <= 2'd0;
      r_wsel       <= 2'd0;
      r_two        <= 1'b0;
      r_col        <= '0;
      r_tready     <= 1'b0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_lc         <= 1'b0;
      r_cmd_last   <= 1'b0;
      r_pend_first <= 1'b0;
      r_pend_mid   <= 1'b0;
      r_pend_last  <= 1'b0;
      r_pend_lc    <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pend_first <= 1'b0;
          r_pend_mid   <= 1'b0;
          r_pend_last  <= 1'b0;
          r_col        <= '0;
          if (w_go_first | w_go_mid | w_go_last) begin
            r_lc       <= w_cmd_lc;
            r_cmd_last <= w_go_last;
          end
          if (w_go_first) begin
            r_wsel   <= w_sel[1];
            r_two    <= 1'b1;
            r_tready <= 1'b1;
            r_state  <= S_LOAD;
          end else if (w_go_mid) begin
            r_top    <= w_sel[1];
            r_wsel   <= r_top;          // old TOP becomes the new BOT
            r_two    <= 1'b0;
            r_tready <= 1'b1;
            r_state  <= S_LOAD;
          end else if (w_go_last) begin
            r_top    <= w_sel[1];
            r_state  <= S_EMIT;
          end
        end

        S_LOAD: begin
          if (w_beat) begin
            if (w_last_beat) begin
              r_col <= '0;
              if (r_two) begin
                r_two  <= 1'b0;
                r_wsel <= w_sel[2];
              end else begin
                r_tready <= 1'b0;
                r_state  <= S_EMIT;
              end
            end else begin
              r_col <= r_col + 9'd1;
            end
          end
        end

        S_EMIT: begin
          if (r_valid && m_axis_tready && w_last_beat) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (!r_valid || m_axis_tready) begin
            r_valid <= 1'b1;
            r_col   <= w_emit_col;
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                r_win[i][j] <= f_px(w_sel[i], {1'b0, w_emit_col} + 10'(j));
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          if (Stream_first_row | Stream_mid_row | Stream_last_row) begin
            r_pend_first <= Stream_first_row;
            r_pend_mid   <= Stream_mid_row;
            r_pend_last  <= Stream_last_row;
            r_pend_lc    <= last_channel;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign Output_valid  = r_valid;
  assign Done_1row     = r_done;
  assign out_window_00 = r_win[0][0];
  assign out_window_01 = r_win[0][1];
  assign out_window_02 = r_win[0][2];
  assign out_window_10 = r_win[1][0];
  assign out_window_11 = r_win[1][1];
  assign out_window_12 = r_win[1][2];
  assign out_window_20 = r_win[2][0];
  assign out_window_21 = r_win[2][1];
  assign out_window_22 = r_win[2][2];

endmodule
`default_nettype wire

// File: tb/tb_input_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_line_buffer
// Purpose  : Directed self-checking bench for input_line_buffer, N=4 map
//            with pixel (r,c) = 4r+c+1.
// Revision : 1.0  initial release
// ============================================================================
module tb_input_line_buffer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Stream_first_row, Stream_mid_row, Stream_last_row;
  logic [8:0]  IMAGE_SIZE;
  logic        last_channel;
  logic [15:0] dina;
  logic        s_axis_tvalid, s_axis_tlast, m_axis_tready;
  logic        s_axis_tready;
  logic [15:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic        Output_valid, Done_1row;

  int n_cmp = 0;
  int n_err = 0;
  int pix;
  logic [143:0] cap [4];

  always #5 clk = ~clk;

  input_line_buffer #(.DATA_WIDTH(16), .MAX_IMAGE_SIZE(256)) dut (
    .clk(clk), .Reset(Reset),
    .Stream_first_row(Stream_first_row), .Stream_mid_row(Stream_mid_row),
    .Stream_last_row(Stream_last_row), .IMAGE_SIZE(IMAGE_SIZE),
    .last_channel(last_channel), .dina(dina), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_axis_tready(s_axis_tready),
    .out_window_00(w00), .out_window_01(w01), .out_window_02(w02),
    .out_window_10(w10), .out_window_11(w11), .out_window_12(w12),
    .out_window_20(w20), .out_window_21(w21), .out_window_22(w22),
    .Output_valid(Output_valid), .Done_1row(Done_1row)
  );

  task automatic check_val(input string tag, input logic [143:0] got,
                           input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] win_now();
    return {w00, w01, w02, w10, w11, w12, w20, w21, w22};
  endfunction

  // Expected window for output row orow, column col of the 4x4 map.
  function automatic logic [143:0] exp_win(input int orow, input int col);
    logic [143:0] v;
    int r, c;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        r = orow - 1 + i;
        c = col - 1 + j;
        if (r >= 0 && r <= 3 && c >= 0 && c <= 3)
          v[(8 - (3 * i + j)) * 16 +: 16] = 16'(4 * r + c + 1);
      end
    return v;
  endfunction

  // cmd: 0 first, 1 mid, 2 last, 3 first+mid together
  task automatic run_row(input string tag, input int cmd, input int orow,
                         input bit stall, input int exp_beats, input bit lc);
    int beats, wins, dones, cyc;
    bit fin, adv, prev_stall;
    logic [143:0] got, prev;
    beats = 0; wins = 0; dones = 0; cyc = 0;
    fin = 0; prev_stall = 0; prev = '0;
    @(posedge clk); #1;
    Stream_first_row = (cmd == 0 || cmd == 3);
    Stream_mid_row   = (cmd == 1 || cmd == 3);
    Stream_last_row  = (cmd == 2);
    last_channel     = lc;
    s_axis_tvalid    = 1'b1;
    m_axis_tready    = 1'b1;
    dina             = 16'(pix);
    @(posedge clk); #1;
    Stream_first_row = 0; Stream_mid_row = 0; Stream_last_row = 0;
    last_channel = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      got = win_now();
      if (prev_stall) begin
        check_val($sformatf("%s_hold_v", tag), 144'(Output_valid), 144'd1);
        check_val($sformatf("%s_hold_w", tag), got, prev);
      end
      prev_stall = Output_valid && !m_axis_tready;
      prev = got;
      adv = s_axis_tready && s_axis_tvalid;
      if (adv) beats++;
      if (Output_valid && m_axis_tready) begin
        if (wins < 4) begin
          cap[wins] = got;
          check_val($sformatf("%s_win%0d", tag, wins), got, exp_win(orow, wins));
        end
        wins++;
      end
      if (Done_1row) begin
        dones++;
        fin = 1;
      end
      @(posedge clk); #1;
      if (adv) pix++;
      dina = 16'(pix);
      if (stall) begin
        s_axis_tvalid = (cyc % 3 != 1);
        m_axis_tready = (cyc % 2 == 1);
      end
      cyc++;
    end
    check_val($sformatf("%s_timeout", tag), 144'(fin), 144'd1);
    check_val($sformatf("%s_beats", tag), 144'(beats), 144'(exp_beats));
    check_val($sformatf("%s_wins", tag), 144'(wins), 144'd4);
    check_val($sformatf("%s_dones", tag), 144'(dones), 144'd1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check_val($sformatf("%s_done_pulse", tag), 144'(Done_1row), 144'd0);
    check_val($sformatf("%s_idle_vld", tag), 144'(Output_valid), 144'd0);
    check_val($sformatf("%s_idle_rdy", tag), 144'(s_axis_tready), 144'd0);
  endtask

  initial begin
    int cyc;
    Reset = 0;
    Stream_first_row = 0; Stream_mid_row = 0; Stream_last_row = 0;
    IMAGE_SIZE = 9'd4; last_channel = 0; dina = '0;
    s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 1;

    // 1: reset state and idle quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_win", win_now(), '0);
    check_val("rst_vld", 144'(Output_valid), 144'd0);
    check_val("rst_done", 144'(Done_1row), 144'd0);
    check_val("rst_rdy", 144'(s_axis_tready), 144'd0);
    @(posedge clk); #1 Reset = 1;
    s_axis_tvalid = 1; s_axis_tlast = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("idle_rdy", 144'(s_axis_tready), 144'd0);
    check_val("idle_vld", 144'(Output_valid | Done_1row), 144'd0);
    s_axis_tlast = 0;

    // 2-4: full frame
    pix = 1;
    run_row("first", 0, 0, 0, 8, 0);
    check_val("first_c0_hand", cap[0],
              {16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd0, 16'd5, 16'd6});
    check_val("first_c3_hand", cap[3],
              {16'd0, 16'd0, 16'd0, 16'd3, 16'd4, 16'd0, 16'd7, 16'd8, 16'd0});
    run_row("mid1", 1, 1, 0, 4, 0);
    check_val("mid1_c1_hand", cap[1],
              {16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd9, 16'd10, 16'd11});
    run_row("mid2", 1, 2, 0, 4, 0);
    run_row("last", 2, 3, 0, 0, 1);
    check_val("last_c0_hand", cap[0],
              {16'd0, 16'd9, 16'd10, 16'd0, 16'd13, 16'd14, 16'd0, 16'd0, 16'd0});
    // last_channel on the last row cleared the buffers: everything reads 0
    run_row("cleared", 2, 99, 0, 0, 0);

    // 5: priority first>mid, then stalled mid row
    pix = 1;
    run_row("prio", 3, 0, 0, 8, 0);
    run_row("stall", 1, 1, 1, 4, 0);

    // 6: reset during EMIT, then a clean first row
    @(posedge clk); #1 Stream_mid_row = 1; s_axis_tvalid = 1;
    @(posedge clk); #1 Stream_mid_row = 0;
    cyc = 0;
    while (!Output_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("abort_reach", 144'(Output_valid), 144'd1);
    Reset = 0;
    #1;
    check_val("abort_win", win_now(), '0);
    check_val("abort_flags",
              144'({Output_valid, Done_1row, s_axis_tready}), 144'd0);
    repeat (2) @(posedge clk);
    #1 Reset = 1;
    pix = 1;
    run_row("after_rst", 0, 0, 0, 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
